store_buffer: RTL

- Posted-write buffer between the core's load/store datapath and data_memory.
- Core stores are queued in a small FIFO and drained one per cycle into data_memory's synchronous write port when the port is otherwise idle.
- Loads get priority on the shared memory address port and are forwarded from the youngest matching buffered store.
- Core stores therefore complete in one cycle unless the buffer is full.

---
 rtl/store_buffer_pkg.sv | 21 ++
 rtl/store_buffer_fwd.sv | 40 ++++
 rtl/store_buffer.sv | 143 ++++++++++++++
 3 files changed

// File: rtl/store_buffer_pkg.sv
// store_buffer_pkg
// Shared definitions for the posted-write store buffer.
//   SB_ADDR_WIDTH / SB_DATA_WIDTH : default address and data widths; buffered
//                                   entries are stored at these widths
//   sb_entry_t                    : one buffered store {addr, data}
//   sb_ptr_width()                : head/tail pointer width for a given depth
package store_buffer_pkg;

    localparam int SB_ADDR_WIDTH = 32;
    localparam int SB_DATA_WIDTH = 32;

    typedef struct packed {
        logic [SB_ADDR_WIDTH-1:0] addr;
        logic [SB_DATA_WIDTH-1:0] data;
    } sb_entry_t;

    function automatic int sb_ptr_width(input int depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

endpackage

// File: rtl/store_buffer_fwd.sv
// store_buffer_fwd
// Combinational youngest-match search over the buffered stores.
//   entries  : FIFO storage array
//   valid    : one bit per slot, set when the slot holds a buffered store
//   tail_ptr : next slot to be written; the youngest entry sits at tail_ptr-1
//   load_addr: address being loaded
//   hit      : some valid entry matches load_addr
//   data     : data of the youngest matching entry (zero when no hit)
module store_buffer_fwd
    import store_buffer_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int PW    = sb_ptr_width(DEPTH)
) (
    input  sb_entry_t                entries [DEPTH],
    input  logic [DEPTH-1:0]         valid,
    input  logic [PW-1:0]            tail_ptr,
    input  logic [SB_ADDR_WIDTH-1:0] load_addr,
    output logic                     hit,
    output logic [SB_DATA_WIDTH-1:0] data
);

    logic [PW-1:0] idx;

    // Walk from oldest (tail-DEPTH) to youngest (tail-1) so the youngest
    // match is the last assignment and therefore wins.
    always_comb begin
        hit  = 1'b0;
        data = '0;
        idx  = '0;
        for (int k = DEPTH; k >= 1; k--) begin
            idx = tail_ptr - PW'(k);
            if (valid[idx] && (entries[idx].addr == load_addr)) begin
                hit  = 1'b1;
                data = entries[idx].data;
            end
        end
    end

endmodule

// File: rtl/store_buffer.sv
// store_buffer
// Posted-write buffer between the core load/store datapath and data_memory.
// Stores are queued and drained one per cycle whenever the shared memory
// port is not needed by a load; loads forward from the youngest buffered
// store to the same address. A load that keeps the port busy for
// STARVE_LIMIT cycles while stores wait is overridden by a forced drain.
//   CLK, Reset                        : clock, async active-high reset
//   StoreReq/StoreAddr/StoreData      : core store request
//   StoreReady                        : buffer not full
//   LoadReq/LoadAddr/LoadData         : core load request, combinational result
//   CoreStall                         : core must hold its instruction
//   Empty                             : no buffered stores
//   MemAddress/MemWriteData/MemWrite  : data_memory write/address port
//   MemReadData                       : data_memory read data
module store_buffer
    import store_buffer_pkg::*;
#(
    parameter int DEPTH        = 4,
    parameter int ADDR_WIDTH   = SB_ADDR_WIDTH,
    parameter int DATA_WIDTH   = SB_DATA_WIDTH,
    parameter int STARVE_LIMIT = 8
) (
    input  logic                  CLK,
    input  logic                  Reset,
    input  logic                  StoreReq,
    input  logic [ADDR_WIDTH-1:0] StoreAddr,
    input  logic [DATA_WIDTH-1:0] StoreData,
    output logic                  StoreReady,
    input  logic                  LoadReq,
    input  logic [ADDR_WIDTH-1:0] LoadAddr,
    output logic [DATA_WIDTH-1:0] LoadData,
    output logic                  CoreStall,
    output logic                  Empty,
    output logic [ADDR_WIDTH-1:0] MemAddress,
    output logic [DATA_WIDTH-1:0] MemWriteData,
    output logic                  MemWrite,
    input  logic [DATA_WIDTH-1:0] MemReadData
);

    localparam int PW = sb_ptr_width(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);
    localparam int SW = (STARVE_LIMIT > 0) ? $clog2(STARVE_LIMIT + 1) : 1;

    sb_entry_t                entries [DEPTH];
    logic [PW-1:0]            head_ptr;
    logic [PW-1:0]            tail_ptr;
    logic [CW-1:0]            count;
    logic [SW-1:0]            starve;

    logic                     full;
    logic                     not_empty;
    logic                     starved;
    logic                     drain;
    logic                     enq;
    logic [DEPTH-1:0]         valid;
    logic [PW-1:0]            offset;
    logic                     fwd_hit;
    logic [SB_DATA_WIDTH-1:0] fwd_data;

    assign full      = (count == CW'(DEPTH));
    assign not_empty = (count != '0);
    assign starved   = (starve == SW'(STARVE_LIMIT));
    assign drain     = not_empty && (!LoadReq || starved);
    assign enq       = StoreReq && !full;

    assign StoreReady = !full;
    assign Empty      = !not_empty;

    // A slot is valid when its distance from head (mod DEPTH) is below count.
    always_comb begin
        valid  = '0;
        offset = '0;
        for (int i = 0; i < DEPTH; i++) begin
            offset   = PW'(i) - head_ptr;
            valid[i] = (CW'(offset) < count);
        end
    end

    store_buffer_fwd #(
        .DEPTH (DEPTH),
        .PW    (PW)
    ) u_fwd (
        .entries   (entries),
        .valid     (valid),
        .tail_ptr  (tail_ptr),
        .load_addr (SB_ADDR_WIDTH'(LoadAddr)),
        .hit       (fwd_hit),
        .data      (fwd_data)
    );

    // In drain mode the head entry owns the port; otherwise the load does.
    always_comb begin
        MemAddress   = LoadAddr;
        MemWriteData = '0;
        MemWrite     = 1'b0;
        if (drain) begin
            MemAddress   = ADDR_WIDTH'(entries[head_ptr].addr);
            MemWriteData = DATA_WIDTH'(entries[head_ptr].data);
            MemWrite     = 1'b1;
        end
    end

    assign LoadData = fwd_hit ? DATA_WIDTH'(fwd_data) : MemReadData;

    // A drain while LoadReq is high can only be a forced drain; the load
    // then has no port unless forwarding already covers it.
    assign CoreStall = (StoreReq && full) || (LoadReq && drain && !fwd_hit);

    // Entry storage needs no reset: validity comes from head/count.
    always_ff @(posedge CLK) begin
        if (enq) begin
            entries[tail_ptr].addr <= SB_ADDR_WIDTH'(StoreAddr);
            entries[tail_ptr].data <= SB_DATA_WIDTH'(StoreData);
        end
    end

    always_ff @(posedge CLK or posedge Reset) begin
        if (Reset) begin
            head_ptr <= '0;
            tail_ptr <= '0;
            count    <= '0;
            starve   <= '0;
        end else begin
            if (enq) begin
                tail_ptr <= tail_ptr + PW'(1);
            end
            if (drain) begin
                head_ptr <= head_ptr + PW'(1);
            end
            if (enq && !drain) begin
                count <= count + CW'(1);
            end else if (drain && !enq) begin
                count <= count - CW'(1);
            end
            if (drain || !not_empty) begin
                starve <= '0;
            end else if (LoadReq && !starved) begin
                starve <= starve + SW'(1);
            end
        end
    end

endmodule
